// File: rtl/fp_norm_ctrl.sv
// Handshaked mantissa normalizer: leading-zero count, exponent-limited left shift.
// Optional abort input enabled by defining FP_NORM_FLUSH_EN.
module lzc_24bits (
  input  logic [23:0] a,
  output logic [4:0]  cnt
);
  // Scan upward so the highest set bit has the final say.
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (a[i]) cnt = 5'(23 - i);
    end
  end
endmodule

module fp_norm_ctrl #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_uflow,
  output logic [15:0]       norm_cnt
`ifdef FP_NORM_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SW = EXP_W + 5;

  state_t            state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [4:0]        lzc_q, lzc_d;
  logic              zero_q, zero_d;
  logic [MANT_W-1:0] out_mant_q, out_mant_d;
  logic [EXP_W-1:0]  out_exp_q, out_exp_d;
  logic              out_zero_q, out_zero_d;
  logic              out_uflow_q, out_uflow_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [4:0]        lzc_cnt;
  logic [SW-1:0]     lz_w, ex_w, sh;

  lzc_24bits u_lzc (
    .a   (mant_q),
    .cnt (lzc_cnt)
  );

  assign lz_w = SW'(lzc_q);
  assign ex_w = SW'(exp_q);
  assign sh   = (lz_w > ex_w) ? ex_w : lz_w;

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    lzc_d       = lzc_q;
    zero_d      = zero_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mant_d  = in_mant;
          exp_d   = in_exp;
          state_d = COUNT;
        end
      end
      COUNT: begin
        lzc_d   = lzc_cnt;
        zero_d  = (mant_q == '0);
        state_d = SHIFT;
      end
      SHIFT: begin
        if (zero_q) begin
          out_mant_d  = '0;
          out_exp_d   = '0;
          out_zero_d  = 1'b1;
          out_uflow_d = 1'b0;
        end else begin
          out_mant_d  = mant_q << sh;
          out_exp_d   = exp_q - EXP_W'(sh);
          out_zero_d  = 1'b0;
          out_uflow_d = (lz_w > ex_w);
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready && out_valid_q) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef FP_NORM_FLUSH_EN
    // Abort keeps the last published result but retracts its valid.
    if (flush) begin
      state_d     = IDLE;
      mant_d      = mant_q;
      exp_d       = exp_q;
      out_mant_d  = out_mant_q;
      out_exp_d   = out_exp_q;
      out_zero_d  = out_zero_q;
      out_uflow_d = out_uflow_q;
      cnt_d       = cnt_q;
    end
`endif
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      lzc_q       <= '0;
      zero_q      <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      lzc_q       <= lzc_d;
      zero_q      <= zero_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;
  assign norm_cnt  = cnt_q;

endmodule

// File: tb/tb_fp_norm_ctrl.sv
// Directed bench for fp_norm_ctrl; covers the flush path when FP_NORM_FLUSH_EN is defined.
module tb_fp_norm_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_mant;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_uflow;
  logic [15:0] norm_cnt;
`ifdef FP_NORM_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_norm_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_uflow (out_uflow),
    .norm_cnt  (norm_cnt)
`ifdef FP_NORM_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    chk({tag, "_iready"}, 32'(in_ready), 32'd1);
    chk({tag, "_mant"}, 32'(out_mant), 32'd0);
    chk({tag, "_exp"}, 32'(out_exp), 32'd0);
    chk({tag, "_zero"}, 32'(out_zero), 32'd0);
    chk({tag, "_uflow"}, 32'(out_uflow), 32'd0);
    chk({tag, "_cnt"}, 32'(norm_cnt), 32'd0);
  endtask

  // Accept an operand and walk to DONE, checking latency along the way.
  task automatic issue(input string tag, input logic [23:0] m,
                       input logic [7:0] e);
    in_valid = 1'b1;
    in_mant  = m;
    in_exp   = e;
    chk({tag, "_accept_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_n1_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_n1_rdy"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_n2_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_n3_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [23:0] m,
                              input logic [7:0] e, input logic z,
                              input logic u);
    chk({tag, "_mant"}, 32'(out_mant), 32'(m));
    chk({tag, "_exp"}, 32'(out_exp), 32'(e));
    chk({tag, "_zero"}, 32'(out_zero), 32'(z));
    chk({tag, "_uflow"}, 32'(out_uflow), 32'(u));
  endtask

  task automatic take(input string tag, input logic [15:0] cnt);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_cnt"}, 32'(norm_cnt), 32'(cnt));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    issue("v1", 24'h000001, 8'd100);
    check_result("v1", 24'h800000, 8'd77, 1'b0, 1'b0);
    take("v1", 16'd1);

    issue("v2", 24'h800000, 8'd5);
    check_result("v2", 24'h800000, 8'd5, 1'b0, 1'b0);
    take("v2", 16'd2);

    issue("v3", 24'h000000, 8'd50);
    check_result("v3", 24'h000000, 8'd0, 1'b1, 1'b0);
    take("v3", 16'd3);

    issue("v4", 24'h000100, 8'd10);
    check_result("v4", 24'h040000, 8'd0, 1'b0, 1'b1);
    take("v4", 16'd4);

    issue("v5", 24'h000003, 8'd0);
    check_result("v5", 24'h000003, 8'd0, 1'b0, 1'b1);
    take("v5", 16'd5);

    // Back-pressure with a competing request
    issue("stall", 24'h00F000, 8'd20);
    in_valid = 1'b1;
    in_mant  = 24'h000001;
    in_exp   = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_rdy", i), 32'(in_ready), 32'd0);
      check_result($sformatf("stall%0d", i), 24'hF00000, 8'd12,
                   1'b0, 1'b0);
    end
    in_valid = 1'b0;
    take("stall", 16'd6);
    repeat (4) @(negedge clk);
    chk("stall_noqueue_valid", 32'(out_valid), 32'd0);
    chk("stall_noqueue_cnt", 32'(norm_cnt), 32'd6);

    // Reset mid-operation while in COUNT
    in_valid = 1'b1;
    in_mant  = 24'h000010;
    in_exp   = 8'd40;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst_count");
    repeat (4) @(negedge clk);
    chk("rst_count_later_valid", 32'(out_valid), 32'd0);
    chk("rst_count_later_cnt", 32'(norm_cnt), 32'd0);

`ifdef FP_NORM_FLUSH_EN
    issue("pre_fl", 24'h000002, 8'd30);
    check_result("pre_fl", 24'h800000, 8'd8, 1'b0, 1'b0);
    take("pre_fl", 16'd1);
    in_valid = 1'b1;
    in_mant  = 24'h000000;
    in_exp   = 8'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_rdy", 32'(in_ready), 32'd1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    check_result("flush_keep", 24'h800000, 8'd8, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("flush_later_valid", 32'(out_valid), 32'd0);
    chk("flush_later_cnt", 32'(norm_cnt), 32'd1);
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("flush_idle_noaccept", 32'(out_valid), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
